// File: rtl/avalon_rsa_pkg.sv
// Shared widths and parameter limits for the RSA accelerator's 256-bit Avalon-MM fabric.
package avalon_rsa_pkg;

    localparam int unsigned AVM_DATA_W       = 256;
    localparam int unsigned AVM_ADDR_W       = 32;
    localparam int unsigned AVM_BYTE_SHIFT   = 5;
    localparam int unsigned MIN_READ_LATENCY = 1;
    localparam int unsigned MAX_READ_LATENCY = 8;
    localparam int unsigned MAX_WAIT_CYCLES  = 7;
    localparam int unsigned WCNT_W           = 3;

endpackage

// File: rtl/avalon_wide_responder_if.sv
// Avalon-MM slave port bundle between the RSA master and the wide responder.
interface avalon_wide_responder_if;
    import avalon_rsa_pkg::*;

    logic [AVM_ADDR_W-1:0] avs_s0_address;
    logic                  avs_s0_read;
    logic                  avs_s0_write;
    logic [AVM_DATA_W-1:0] avs_s0_writedata;
    logic                  avs_s0_waitrequest;
    logic [AVM_DATA_W-1:0] avs_s0_readdata;
    logic                  avs_s0_readdatavalid;

    modport master (
        output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        input  avs_s0_waitrequest, avs_s0_readdata, avs_s0_readdatavalid
    );

    modport slave (
        input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        output avs_s0_waitrequest, avs_s0_readdata, avs_s0_readdatavalid
    );

endinterface

// File: rtl/avalon_rd_pipe.sv
// Fixed-latency valid/data delay line for read responses.
module avalon_rd_pipe #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned WIDTH   = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q [LATENCY];

    // Data stages only load behind a valid, so the last stage holds the previous response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int k = 0; k < int'(LATENCY); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int k = 1; k < int'(LATENCY); k++) begin
                valid_q[k] <= valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/avalon_wide_responder.sv
// 256-bit Avalon-MM slave buffer with programmable wait states and pipelined read latency.
module avalon_wide_responder
    import avalon_rsa_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WAIT_CYCLES  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    avalon_wide_responder_if.slave  bus,
    output logic [15:0]             rd_count,
    output logic [15:0]             wr_count,
    output logic                    err_flag
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [15:0]           rd_count_q, wr_count_q;
    logic                  err_q;
    logic                  cmd, accept, wr_acc, rd_acc, misaligned, both;
    logic [IDX_W-1:0]      idx;
    logic [AVM_DATA_W-1:0] mem [DEPTH];
    logic [AVM_DATA_W-1:0] rd_word;
    logic                  unused_addr_bits;

    assign cmd        = bus.avs_s0_read | bus.avs_s0_write;
    assign both       = bus.avs_s0_read & bus.avs_s0_write;
    assign bus.avs_s0_waitrequest = ~reset | (cmd & (wcnt_q != WCNT_W'(WAIT_CYCLES)));
    assign accept     = cmd & ~bus.avs_s0_waitrequest;
    assign wr_acc     = accept & bus.avs_s0_write;
    // A colliding read is dropped; the write wins.
    assign rd_acc     = accept & bus.avs_s0_read & ~bus.avs_s0_write;
    assign idx        = bus.avs_s0_address[AVM_BYTE_SHIFT +: IDX_W];
    assign misaligned = |bus.avs_s0_address[AVM_BYTE_SHIFT-1:0];
    assign rd_word    = mem[idx];

    // Upper address bits wrap modulo DEPTH.
    assign unused_addr_bits = ^bus.avs_s0_address[AVM_ADDR_W-1:AVM_BYTE_SHIFT+IDX_W];

    always_comb begin
        wcnt_d = wcnt_q;
        if (accept || !cmd) begin
            wcnt_d = '0;
        end else if (wcnt_q < WCNT_W'(WAIT_CYCLES)) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q     <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            if (rd_acc) rd_count_q <= rd_count_q + 16'd1;
            if (wr_acc) wr_count_q <= wr_count_q + 16'd1;
            if (accept && (misaligned || both)) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[idx] <= bus.avs_s0_writedata;
        end
    end

    avalon_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (AVM_DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (bus.avs_s0_readdatavalid),
        .out_data  (bus.avs_s0_readdata)
    );

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign err_flag = err_q;

endmodule

// File: doc/avalon_wide_responder.md
# avalon_wide_responder

Avalon-MM slave responder with a 256-bit data path and a word-organised storage array. It answers the RSA accelerator's 256-bit Avalon-MM master on the other side of the same interface. It serves as the on-chip operand/result buffer and as the DRAM stand-in for block-level simulation of the master. It inserts configurable wait states via `waitrequest` and returns read data with a fixed pipelined latency via `readdatavalid`, matching the handshake the master expects.

## Interface
- `DEPTH`, 16: number of 256-bit words stored; power of two, ≥2.
- `READ_LATENCY`, 2: cycles from read acceptance to `readdatavalid`; range 1..8.
- `WAIT_CYCLES`, 1: `waitrequest` cycles inserted before each command is accepted; range 0..7.
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low reset.
- `avs_s0_address` in 32: byte address; word index = `address[5 +: log2(DEPTH)]`.
- `avs_s0_read` in 1: read command.
- `avs_s0_write` in 1: write command.
- `avs_s0_writedata` in 256: write data; byte k at bits [8k+7:8k].
- `avs_s0_waitrequest` out 1: command not accepted this cycle.
- `avs_s0_readdata` out 256: read data, valid only with `readdatavalid`.
- `avs_s0_readdatavalid` out 1: one-cycle pulse per accepted read.
- `rd_count` out 16: accepted reads since reset; wraps at 2^16.
- `wr_count` out 16: accepted writes since reset; wraps.
- `err_flag` out 1: sticky protocol error (read and write together, or misaligned address).

## Operation
- Command presence: `cmd = read | write`. The master holds the command and address stable while `waitrequest` is high.
- A wait counter `wcnt` (3 bits) increments each cycle `cmd` is high and `wcnt < WAIT_CYCLES`.
- `waitrequest = cmd & (wcnt != WAIT_CYCLES)`, combinational. With `WAIT_CYCLES=0`, commands are accepted in the cycle they appear. While `reset` is low, `waitrequest` is forced to 1.
- Acceptance: `cmd & ~waitrequest` at a rising edge.
  - `wcnt` clears to 0 on acceptance.
  - `wcnt` also clears when `cmd` drops without acceptance.
  - Back-to-back commands each pay `WAIT_CYCLES`.
- Accepted write: `mem[idx]` ← `writedata` at that edge; `wr_count`+1.
- Accepted read:
  - `mem[idx]` is sampled at the acceptance edge into stage 0 of a `READ_LATENCY`-deep valid/data shift pipeline; `rd_count`+1.
  - A write accepted later does not alter data already in flight.
- Address handling: the upper address bits beyond the index wrap modulo `DEPTH`. If `address[4:0] != 0`, the bits are ignored and `err_flag` is set on acceptance.
- Simultaneous read and write: the write is performed, the read is dropped (no `readdatavalid`, `rd_count` unchanged), and `err_flag` is set.
- Reset:
  - Clears `wcnt`, the pipeline valids, `readdatavalid` (0), `readdata` (0), the counters (0) and `err_flag` (0).
  - Memory contents are not reset.
  - Reads in flight when reset asserts are discarded and never return.

## Timing
- Read accepted in cycle A: `readdatavalid`=1 in cycle A+`READ_LATENCY` only, with `readdata`=`mem[idx]` as of the end of cycle A−1 plus any write accepted in cycle A−1 or earlier.
- Reads are pipelined. One read may be accepted every `WAIT_CYCLES+1` cycles; responses return in order, one per accepted read. There is no response backpressure.
- Read-after-write: a write accepted in cycle W is visible to a read accepted in cycle W+1.
- `readdata` holds its last value when `readdatavalid`=0.

## Structure
- Shared package `avalon_rsa_pkg`:
  - `AVM_DATA_W`=256, `AVM_ADDR_W`=32.
  - `AVM_BYTE_SHIFT`=5.
  - Latency and wait-range limits.
- Sub-module `avalon_rd_pipe`: the parameterised valid/data delay line (`READ_LATENCY` stages, async active-low clear of valids). Wait counter, memory and counters stay in the top.
- Memory is a plain register array with no reset, inferable as block RAM only when `READ_LATENCY`≥1 (always true).

## Test plan
- **Single write/read** (defaults): write 0x…A5 (all bytes 0xA5) to address 64; read address 64. Required: `waitrequest` high 1 cycle per command; `readdatavalid` exactly 2 cycles after read acceptance with all bytes 0xA5; `wr_count`=1, `rd_count`=1.
- **Pipelined reads**: preload words 0–9 with pattern word k byte j = k+j, then issue 10 back-to-back reads at 0,32,…,288. Required: 10 in-order `readdatavalid` pulses, correct words, no extra pulses.
- **Wait sweep**: `WAIT_CYCLES`=0,3,7 × `READ_LATENCY`=1,4,8. Required: `waitrequest` high exactly `WAIT_CYCLES` cycles per command; data at acceptance+`READ_LATENCY`.
- **Wrap**: write 0x1 to address 512 with `DEPTH`=16, then read address 0. Required: data 0x1, `err_flag`=0.
- **Error cases**:
  - Read at address 33: `err_flag`=1, data = word 1.
  - Read and write asserted together: write performed, no `readdatavalid`, `err_flag` stays 1.
- **Reset mid-read**: accept a read, then pull `reset` low for 1 cycle before the response. Required: no `readdatavalid`, counters 0, memory intact on the next read.
